m_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory port (async read, write on rising clock edge, word-addressed by address[31:2]) between the processor (port 0) and a secondary master such as a loader or DMA engine (port 1). It sits between the masters and the data memory. It grants one access per cycle using round-robin priority with optional lock holding. It suppresses writes to illegal addresses, records the first error, and counts granted accesses per port.

---
 rtl/m_dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_m_dmem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m_dmem_arbiter.sv
// Two-port round-robin arbiter with lock holding in front of a single data-memory port.
// It blocks illegal accesses, keeps a sticky record of the first error and counts grants per port.
module m_dmem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'd512,
  parameter int          CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_we0,
  input  logic             i_we1,
  input  logic [31:0]      i_addr0,
  input  logic [31:0]      i_addr1,
  input  logic [31:0]      i_wdata0,
  input  logic [31:0]      i_wdata1,
  input  logic             i_lock0,
  input  logic             i_lock1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic [31:0]      o_rdata0,
  output logic [31:0]      o_rdata1,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic [31:0]      i_mem_rdata,
  input  logic             i_err_clr,
  output logic             o_err,
  output logic             o_err_src,
  output logic [31:0]      o_err_addr,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1
);

  localparam logic [1:0] LK_NONE = 2'b00;
  localparam logic [1:0] LK_P0   = 2'b01;
  localparam logic [1:0] LK_P1   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_last;
  logic [1:0]       r_lock;
  logic             r_err;
  logic             r_err_src;
  logic [31:0]      r_err_addr;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_we;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_illegal;

  function automatic logic f_illegal(input logic [31:0] a);
    return (a >= ADDR_LIMIT) || (a[1:0] != 2'b00);
  endfunction

  // Grant selection: a live lock wins, then a lone requester, then the port not served last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if ((r_lock == LK_P0) && i_req0) begin
      w_gnt0 = 1'b1;
    end else if ((r_lock == LK_P1) && i_req1) begin
      w_gnt1 = 1'b1;
    end else if (i_req0 && i_req1) begin
      if (r_last) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end else if (i_req0) begin
      w_gnt0 = 1'b1;
    end else if (i_req1) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = 1'b0;
    end
  end

  // Route the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = 32'h0000_0000;
    w_wdata = 32'h0000_0000;
    case ({w_gnt1, w_gnt0})
      2'b01: begin
        w_we    = i_we0;
        w_addr  = i_addr0;
        w_wdata = i_wdata0;
      end
      2'b10: begin
        w_we    = i_we1;
        w_addr  = i_addr1;
        w_wdata = i_wdata1;
      end
      default: begin
        w_we    = 1'b0;
        w_addr  = 32'h0000_0000;
        w_wdata = 32'h0000_0000;
      end
    endcase
  end

  // The grant still completes on an illegal access so the requester never stalls.
  assign w_illegal   = (w_gnt0 | w_gnt1) & f_illegal(w_addr);
  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_mem_we    = w_we & ~w_illegal;
  assign o_mem_addr  = w_addr;
  assign o_mem_wdata = w_wdata;
  assign o_rdata0    = (w_gnt0 && !w_illegal) ? i_mem_rdata : 32'h0000_0000;
  assign o_rdata1    = (w_gnt1 && !w_illegal) ? i_mem_rdata : 32'h0000_0000;

  // Round-robin history and lock ownership; a cycle without a grant drops any lock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last <= 1'b1;
      r_lock <= LK_NONE;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
      r_lock <= i_lock0 ? LK_P0 : LK_NONE;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
      r_lock <= i_lock1 ? LK_P1 : LK_NONE;
    end else begin
      r_lock <= LK_NONE;
    end
  end

  // Sticky first-error capture; a new error beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err      <= 1'b0;
      r_err_src  <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else if (w_illegal && (!r_err || i_err_clr)) begin
      r_err      <= 1'b1;
      r_err_src  <= w_gnt1;
      r_err_addr <= w_addr;
    end else if (i_err_clr) begin
      r_err      <= 1'b0;
      r_err_src  <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end
  end

  // Saturating per-port grant counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_gnt0 && (r_cnt0 != CNT_MAX)) begin
        r_cnt0 <= r_cnt0 + CNT_ONE;
      end
      if (w_gnt1 && (r_cnt1 != CNT_MAX)) begin
        r_cnt1 <= r_cnt1 + CNT_ONE;
      end
    end
  end

  assign o_err      = r_err;
  assign o_err_src  = r_err_src;
  assign o_err_addr = r_err_addr;
  assign o_cnt0     = r_cnt0;
  assign o_cnt1     = r_cnt1;

endmodule

// File: tb/tb_m_dmem_arbiter.sv
// Self-checking bench for m_dmem_arbiter: a table of per-cycle vectors fed through a
// scoreboard queue, plus hand sequences for counter saturation and port-0 lock holding.
module tb_m_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        lk0 = 1'b0, lk1 = 1'b0, clr = 1'b0;
  logic [31:0] a0 = 32'h0, a1 = 32'h0, d0 = 32'h0, d1 = 32'h0;
  logic        gnt0, gnt1, mem_we, err, err_src;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata, err_addr;
  logic [15:0] cnt0, cnt1;
  logic        tb_load = 1'b1;
  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst, r0, r1, w0, w1, l0, l1, cl;
    logic [31:0] a0, a1, d0, d1;
    logic g0, g1, we;
    logic [31:0] rd0, rd1;
    logic e, es;
    logic [31:0] ea;
    logic [15:0] c0, c1;
  } vec_t;

  typedef struct {
    logic g0, g1, we;
    logic [31:0] rd0, rd1, ma, md;
    logic e, es;
    logic [31:0] ea;
    logic [15:0] c0, c1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  m_dmem_arbiter #(.ADDR_LIMIT(32'd512), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(a0), .i_addr1(a1), .i_wdata0(d0), .i_wdata1(d1),
    .i_lock0(lk0), .i_lock1(lk1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_err_clr(clr),
    .o_err(err), .o_err_src(err_src), .o_err_addr(err_addr),
    .o_cnt0(cnt0), .o_cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: async read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h0BAD_F00D;
      mem[1]   <= 32'h1111_1111;
      mem[2]   <= 32'h2222_2222;
      mem[4]   <= 32'hDEAD_BEEF;
      mem[127] <= 32'h7F7F_7F7F;
    end else if (mem_we) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  function automatic vec_t mkv(
    input logic rst, r0, r1, w0, w1, l0, l1, cl,
    input logic [31:0] xa0, xa1, xd0, xd1,
    input logic g0, g1, we,
    input logic [31:0] rd0, rd1,
    input logic e, es, input logic [31:0] ea,
    input logic [15:0] c0, c1);
    vec_t v;
    v = '{rst, r0, r1, w0, w1, l0, l1, cl, xa0, xa1, xd0, xd1,
          g0, g1, we, rd0, rd1, e, es, ea, c0, c1};
    return v;
  endfunction

  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lk0 = 1'b0; lk1 = 1'b0; clr = 1'b0;
    a0 = 32'h0; a1 = 32'h0; d0 = 32'h0; d1 = 32'h0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    exp_t x;
    vec_t v;
    logic [31:0] Z;
    Z = 32'h0;
    // rst r0 r1 w0 w1 l0 l1 cl | a0 a1 d0 d1 | g0 g1 we | rd0 rd1 | err src eaddr | c0 c1
    tbl.push_back(mkv(1,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 0,0,Z, 0,0));
    tbl.push_back(mkv(0,1,0,0,0,0,0,0, 32'h10,Z,Z,Z, 1,0,0, 32'hDEADBEEF,Z, 0,0,Z, 0,0));
    tbl.push_back(mkv(0,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 0,0,Z, 1,0));
    tbl.push_back(mkv(1,1,1,0,0,0,0,0, 32'h4,32'h8,Z,Z, 1,0,0, 32'h11111111,Z, 0,0,Z, 0,0));
    tbl.push_back(mkv(0,1,1,0,0,0,0,0, 32'h4,32'h8,Z,Z, 0,1,0, Z,32'h22222222, 0,0,Z, 1,0));
    tbl.push_back(mkv(0,1,1,0,0,0,0,0, 32'h4,32'h8,Z,Z, 1,0,0, 32'h11111111,Z, 0,0,Z, 1,1));
    tbl.push_back(mkv(0,1,1,0,0,0,0,0, 32'h4,32'h8,Z,Z, 0,1,0, Z,32'h22222222, 0,0,Z, 2,1));
    tbl.push_back(mkv(0,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 0,0,Z, 2,2));
    tbl.push_back(mkv(0,0,1,0,1,0,1,0, Z,32'h20,Z,32'h55, 0,1,1, Z,Z, 0,0,Z, 2,2));
    tbl.push_back(mkv(0,1,1,0,1,0,1,0, 32'h4,32'h20,Z,32'h55, 0,1,1, Z,32'h55, 0,0,Z, 2,3));
    tbl.push_back(mkv(0,1,1,0,1,0,0,0, 32'h4,32'h20,Z,32'h55, 0,1,1, Z,32'h55, 0,0,Z, 2,4));
    tbl.push_back(mkv(0,1,1,0,1,0,0,0, 32'h4,32'h20,Z,32'h55, 1,0,0, 32'h11111111,Z, 0,0,Z, 2,5));
    tbl.push_back(mkv(0,0,1,0,0,0,0,0, Z,32'h20,Z,Z, 0,1,0, Z,32'h55, 0,0,Z, 3,5));
    tbl.push_back(mkv(0,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 0,0,Z, 3,6));
    tbl.push_back(mkv(0,1,0,1,0,0,0,0, 32'h200,Z,32'hAA,Z, 1,0,0, Z,Z, 0,0,Z, 3,6));
    tbl.push_back(mkv(0,0,1,0,1,0,0,0, Z,32'h6,Z,32'hBB, 0,1,0, Z,Z, 1,0,32'h200, 4,6));
    tbl.push_back(mkv(0,0,1,0,0,0,0,1, Z,32'h6,Z,Z, 0,1,0, Z,Z, 1,0,32'h200, 4,7));
    tbl.push_back(mkv(0,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 1,1,32'h6, 4,8));
    tbl.push_back(mkv(0,0,0,0,0,0,0,1, Z,Z,Z,Z, 0,0,0, Z,Z, 1,1,32'h6, 4,8));
    tbl.push_back(mkv(0,1,0,0,0,0,0,0, 32'h1FC,Z,Z,Z, 1,0,0, 32'h7F7F7F7F,Z, 0,0,Z, 4,8));
    tbl.push_back(mkv(0,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 0,0,Z, 5,8));
    tbl.push_back(mkv(0,0,1,0,0,0,1,0, Z,32'h8,Z,Z, 0,1,0, Z,32'h22222222, 0,0,Z, 5,8));
    tbl.push_back(mkv(0,1,1,0,0,0,1,0, 32'h4,32'h8,Z,Z, 0,1,0, Z,32'h22222222, 0,0,Z, 5,9));
    tbl.push_back(mkv(1,1,1,0,0,0,1,0, 32'h4,32'h8,Z,Z, 1,0,0, 32'h11111111,Z, 0,0,Z, 0,0));
    tbl.push_back(mkv(0,0,0,0,0,0,0,0, Z,Z,Z,Z, 0,0,0, Z,Z, 0,0,Z, 1,0));

    @(posedge clk);
    #1;
    tb_load = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.rst) pulse_reset();
      req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
      lk0 = v.l0; lk1 = v.l1; clr = v.cl;
      a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1;
      x.g0 = v.g0; x.g1 = v.g1; x.we = v.we; x.rd0 = v.rd0; x.rd1 = v.rd1;
      x.ma = v.g1 ? v.a1 : (v.g0 ? v.a0 : 32'h0);
      x.md = v.g1 ? v.d1 : (v.g0 ? v.d0 : 32'h0);
      x.e = v.e; x.es = v.es; x.ea = v.ea; x.c0 = v.c0; x.c1 = v.c1;
      sb.push_back(x);
      @(negedge clk);
      x = sb.pop_front();
      chk($sformatf("v%0d_gnt0", i), {31'h0, gnt0}, {31'h0, x.g0});
      chk($sformatf("v%0d_gnt1", i), {31'h0, gnt1}, {31'h0, x.g1});
      chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, x.we});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, x.ma);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, x.md);
      chk($sformatf("v%0d_rdata0", i), rdata0, x.rd0);
      chk($sformatf("v%0d_rdata1", i), rdata1, x.rd1);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, x.e});
      chk($sformatf("v%0d_err_src", i), {31'h0, err_src}, {31'h0, x.es});
      chk($sformatf("v%0d_err_addr", i), err_addr, x.ea);
      chk($sformatf("v%0d_cnt0", i), {16'h0, cnt0}, {16'h0, x.c0});
      chk($sformatf("v%0d_cnt1", i), {16'h0, cnt1}, {16'h0, x.c1});
      @(posedge clk);
      #1;
    end
    drive_idle();

    chk("mem_0x20_written", mem[8], 32'h0000_0055);
    chk("mem_0x0_untouched", mem[0], 32'h0BAD_F00D);
    chk("mem_0x4_untouched", mem[1], 32'h1111_1111);

    // Port 0 lock: held through a tie it would otherwise lose, released a cycle after i_lock0 drops.
    pulse_reset();
    req0 = 1'b1; lk0 = 1'b1; a0 = 32'h4;
    @(negedge clk); chk("lk0_c0_gnt0", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1;
    req1 = 1'b1; a1 = 32'h8;
    @(negedge clk); chk("lk0_c1_gnt0", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1;
    lk0 = 1'b0;
    @(negedge clk); chk("lk0_c2_gnt0", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk); chk("lk0_c3_gnt1", {31'h0, gnt1}, 32'h1);
    @(posedge clk); #1;
    drive_idle();

    // Counter saturation after 0xFFFE grants to port 0.
    pulse_reset();
    req0 = 1'b1; a0 = 32'h4;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_cnt0_fffe", {16'h0, cnt0}, 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sat_gnt0_%0d", k), {31'h0, gnt0}, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt0_%0d", k), {16'h0, cnt0}, 32'h0000_FFFF);
    end
    drive_idle();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_keeps_cnt0", {16'h0, cnt0}, 32'h0000_FFFF);
    chk("clr_keeps_cnt1", {16'h0, cnt1}, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
